// File: rtl/alu_ctrl_pkg.sv
// Shared constants for alu_ctrl: ULA COND opcodes, FSM state encoding, default width.
package alu_ctrl_pkg;

    localparam int ALU_W_DEFAULT = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl.sv
// Command/result stream controller around an external combinational 8-bit ULA.
// Optional accumulator operand source enabled by defining ALU_CTRL_ACC_EN.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int W     = ALU_W_DEFAULT,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic             CMD_SRC,
    input  logic [W-1:0]     CMD_A,
    input  logic [W-1:0]     CMD_B,
    output logic [W-1:0]     ALU_A,
    output logic [W-1:0]     ALU_B,
    output logic [1:0]       ALU_COND,
    input  logic [W-1:0]     ALU_OUT,
    input  logic             ALU_CARRY,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [W-1:0]     RES_DATA,
    output logic             RES_CARRY,
    output logic [CNT_W-1:0] OP_COUNT
);

    state_t             state_r;
    state_t             state_next_s;
    logic               accept_s;
    logic               deliver_s;
    logic               cmd_ready_r;
    logic [W-1:0]       alu_a_r;
    logic [W-1:0]       alu_b_r;
    logic [1:0]         alu_cond_r;
    logic               res_valid_r;
    logic [W-1:0]       res_data_r;
    logic               res_carry_r;
    logic [CNT_W-1:0]   op_count_r;
    logic [W-1:0]       operand_a_s;

`ifdef ALU_CTRL_ACC_EN
    logic [W-1:0]       acc_r;

    // Operand A comes from the accumulator when the command asks for it
    always_comb begin
        operand_a_s = CMD_A;
        if (CMD_SRC) begin
            operand_a_s = acc_r;
        end else begin
            operand_a_s = CMD_A;
        end
    end

    // Accumulator follows each result as it is captured from the ULA
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_r <= {W{1'b0}};
        end else if (state_r == ST_EXEC) begin
            acc_r <= ALU_OUT;
        end else begin
            acc_r <= acc_r;
        end
    end
`else
    logic               unused_src_s;

    assign unused_src_s = CMD_SRC;

    // Without the accumulator, operand A is always the command operand
    always_comb begin
        operand_a_s = CMD_A;
    end
`endif

    // Next-state logic and handshake qualifiers
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        deliver_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                if (RES_READY) begin
                    deliver_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, ULA operand registers and result stream registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
            alu_a_r     <= {W{1'b0}};
            alu_b_r     <= {W{1'b0}};
            alu_cond_r  <= OP_ADD;
            res_valid_r <= 1'b0;
            res_data_r  <= {W{1'b0}};
            res_carry_r <= 1'b0;
            op_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            cmd_ready_r <= (state_next_s == ST_IDLE);
            if (accept_s) begin
                alu_a_r    <= operand_a_s;
                alu_b_r    <= CMD_B;
                alu_cond_r <= CMD_OP;
            end else begin
                alu_a_r    <= alu_a_r;
                alu_b_r    <= alu_b_r;
                alu_cond_r <= alu_cond_r;
            end
            // ULA carry is always that of A+B, so it only means something for add
            if (state_r == ST_EXEC) begin
                res_valid_r <= 1'b1;
                res_data_r  <= ALU_OUT;
                res_carry_r <= (alu_cond_r == OP_ADD) ? ALU_CARRY : 1'b0;
            end else if (deliver_s) begin
                res_valid_r <= 1'b0;
            end else begin
                res_valid_r <= res_valid_r;
            end
            if (deliver_s) begin
                op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                op_count_r <= op_count_r;
            end
        end
    end

    assign CMD_READY = cmd_ready_r;
    assign ALU_A     = alu_a_r;
    assign ALU_B     = alu_b_r;
    assign ALU_COND  = alu_cond_r;
    assign RES_VALID = res_valid_r;
    assign RES_DATA  = res_data_r;
    assign RES_CARRY = res_carry_r;
    assign OP_COUNT  = op_count_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with a behavioural ULA beside it; honours ALU_CTRL_ACC_EN.
module tb_alu_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic             CMD_SRC;
    logic [W-1:0]     CMD_A;
    logic [W-1:0]     CMD_B;
    logic [W-1:0]     ALU_A;
    logic [W-1:0]     ALU_B;
    logic [1:0]       ALU_COND;
    logic [W-1:0]     ALU_OUT;
    logic             ALU_CARRY;
    logic             RES_VALID;
    logic             RES_READY;
    logic [W-1:0]     RES_DATA;
    logic             RES_CARRY;
    logic [CNT_W-1:0] OP_COUNT;

    typedef struct packed {
        logic [W-1:0] data;
        logic         carry;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] cnt_model = '0;
    logic [W-1:0]     acc_model = '0;
    logic [W:0]       ula_sum;

    always #5 CLK = ~CLK;

    alu_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_SRC(CMD_SRC),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_COND(ALU_COND),
        .ALU_OUT(ALU_OUT), .ALU_CARRY(ALU_CARRY),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY),
        .OP_COUNT(OP_COUNT)
    );

    // Behavioural ULA: carry is always the carry of A+B
    assign ula_sum   = {1'b0, ALU_A} + {1'b0, ALU_B};
    assign ALU_CARRY = ula_sum[W];
    always_comb begin
        case (ALU_COND)
            2'b00:   ALU_OUT = ula_sum[W-1:0];
            2'b01:   ALU_OUT = ALU_A - ALU_B;
            2'b10:   ALU_OUT = ALU_A & ALU_B;
            default: ALU_OUT = ALU_A | ALU_B;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        exp_t r;
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        r.carry = 1'b0;
        case (op)
            2'b00: begin r.data = s[W-1:0]; r.carry = s[W]; end
            2'b01: r.data = a - b;
            2'b10: r.data = a & b;
            default: r.data = a | b;
        endcase
        return r;
    endfunction

    // Result-side scoreboard: compare on each cycle that ends in a handshake
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && RES_VALID && RES_READY) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_data", 32'(RES_DATA), 32'(e.data));
                check("sb_carry", 32'(RES_CARRY), 32'(e.carry));
            end
        end
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                         input logic src, input int hold, input logic use_fixed,
                         input logic [W:0] fixed_exp);
        logic [W-1:0] a_eff;
        exp_t         e;
        logic [W-1:0] held_data;
        int           n;
        n = 0;
        while (!CMD_READY && n < 20) begin
            @(posedge CLK); #1; n++;
        end
        check("cmd_ready_idle", 32'(CMD_READY), 32'd1);
`ifdef ALU_CTRL_ACC_EN
        a_eff = src ? acc_model : a;
`else
        a_eff = a;
`endif
        CMD_VALID = 1'b1; CMD_A = a; CMD_B = b; CMD_OP = op; CMD_SRC = src;
        @(posedge CLK); #1;
        e = model(a_eff, b, op);
        sb.push_back(e);
        acc_model = e.data;
        CMD_VALID = 1'b0;
        check("exec_cmd_ready", 32'(CMD_READY), 32'd0);
        check("exec_res_valid", 32'(RES_VALID), 32'd0);
        check("alu_a", 32'(ALU_A), 32'(a_eff));
        check("alu_b", 32'(ALU_B), 32'(b));
        check("alu_cond", 32'(ALU_COND), 32'(op));
        @(posedge CLK); #1;
        check("done_res_valid", 32'(RES_VALID), 32'd1);
        if (use_fixed) begin
            check("fixed_result", 32'({RES_CARRY, RES_DATA}), 32'(fixed_exp));
        end
        held_data = RES_DATA;
        for (int i = 0; i < hold; i++) begin
            CMD_VALID = 1'b1; CMD_B = ~b; CMD_OP = ~op;
            @(posedge CLK); #1;
            check("bp_valid", 32'(RES_VALID), 32'd1);
            check("bp_data", 32'(RES_DATA), 32'(held_data));
            check("bp_cmd_ready", 32'(CMD_READY), 32'd0);
            check("bp_alu_b", 32'(ALU_B), 32'(b));
            check("bp_count", 32'(OP_COUNT), 32'(cnt_model));
        end
        CMD_VALID = 1'b0;
        RES_READY = 1'b1;
        @(posedge CLK); #1;
        RES_READY = 1'b0;
        cnt_model = cnt_model + 1'b1;
        check("op_count", 32'(OP_COUNT), 32'(cnt_model));
        check("post_res_valid", 32'(RES_VALID), 32'd0);
        check("post_cmd_ready", 32'(CMD_READY), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_SRC = 1'b0;
        CMD_A = '0; CMD_B = '0; RES_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rst_res_valid", 32'(RES_VALID), 32'd0);
        check("rst_res_data", 32'(RES_DATA), 32'd0);
        check("rst_op_count", 32'(OP_COUNT), 32'd0);
        RST = 1'b0;

        do_op(8'd200, 8'd100, 2'b00, 1'b0, 0, 1'b1, 9'h12C);
        do_op(8'd5,   8'd7,   2'b01, 1'b0, 0, 1'b1, 9'h0FE);
        do_op(8'hF0,  8'h3C,  2'b10, 1'b0, 0, 1'b1, 9'h030);
        do_op(8'hF0,  8'h0F,  2'b11, 1'b0, 0, 1'b1, 9'h0FF);
        do_op(8'h81,  8'h90,  2'b00, 1'b0, 4, 1'b1, 9'h111);

        // Reset while the operation is in EXEC: result must vanish uncounted
        CMD_VALID = 1'b1; CMD_A = 8'h11; CMD_B = 8'h22; CMD_OP = 2'b00; CMD_SRC = 1'b0;
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        cnt_model = '0;
        acc_model = '0;
        check("rexec_cmd_ready", 32'(CMD_READY), 32'd1);
        check("rexec_res_valid", 32'(RES_VALID), 32'd0);
        check("rexec_op_count", 32'(OP_COUNT), 32'd0);
        check("rexec_alu", 32'({ALU_A, ALU_B, ALU_COND}), 32'd0);
        RES_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("rexec_no_result", 32'(RES_VALID), 32'd0);
        end
        RES_READY = 1'b0;

        do_op(8'h0A, 8'h05, 2'b00, 1'b0, 0, 1'b1, 9'h00F);
`ifdef ALU_CTRL_ACC_EN
        do_op(8'hFF, 8'h3C, 2'b10, 1'b1, 0, 1'b1, 9'h00C);
`else
        do_op(8'hFF, 8'h3C, 2'b10, 1'b1, 0, 1'b1, 9'h03C);
`endif

        for (int i = 0; i < 254; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 1'b0, 9'h000);
        end
        check("count_wrap", 32'(OP_COUNT), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
